hdmi_period_scheduler: RTL and testbench

HDMI_PERIOD_SCHEDULER -- requirements
Module: hdmi_period_scheduler

---
 rtl/hdmi_pkg.sv | 56 +++++
 rtl/hdmi_rr_pick2.sv | 38 +++
 rtl/hdmi_period_scheduler.sv | 148 ++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared types and timing constants for the HDMI period scheduler.
package hdmi_pkg;

    // Period type presented on the mode output.
    typedef enum logic [2:0] {
        MODE_CONTROL = 3'd0,
        MODE_VID_PRE = 3'd1,
        MODE_VID_GB  = 3'd2,
        MODE_VIDEO   = 3'd3,
        MODE_DI_PRE  = 3'd4,
        MODE_DI_GB   = 3'd5,
        MODE_DI_DATA = 3'd6
    } mode_t;

    // Control state machine states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DI_PRE,
        ST_DI_LGB,
        ST_DI_DATA,
        ST_DI_TGB,
        ST_VID_PRE,
        ST_VID_GB,
        ST_VIDEO
    } state_t;

    // Line timing, in pixel positions.
    localparam logic [9:0] H_TOTAL       = 10'd800;
    localparam logic [9:0] DI_DECIDE     = 10'd2;
    localparam logic [9:0] DI_START      = 10'd4;
    localparam logic [9:0] PKT_LEN       = 10'd32;
    localparam logic [1:0] MAX_PKTS      = 2'd2;
    localparam logic [9:0] VID_PRE_START = 10'd134;
    localparam logic [9:0] VID_START     = 10'd144;
    localparam logic [9:0] VID_END       = 10'd784;

    // Derived island / video landmarks.
    localparam logic [9:0] DI_GB_START   = DI_START + 10'd8;
    localparam logic [9:0] DI_DATA_START = DI_START + 10'd10;
    localparam logic [9:0] VID_GB_START  = VID_START - 10'd2;

    // Preamble codes, CTL3..CTL0.
    localparam logic [3:0] CTL_DI_PRE  = 4'b0101;
    localparam logic [3:0] CTL_VID_PRE = 4'b0001;

    // Next source index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] rr_inc(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Source index to one-hot grant vector.
    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/hdmi_rr_pick2.sv
// Round-robin selection of up to two of three requesters, starting at ptr.
module hdmi_rr_pick2
    import hdmi_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] count,
    output logic [1:0] first_idx,
    output logic [1:0] second_idx,
    output logic [1:0] next_ptr
);

    logic [1:0] idx;

    // Walk the three sources in rotation order, taking at most two.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        count      = 2'd0;
        first_idx  = 2'd0;
        second_idx = 2'd0;
        next_ptr   = ptr;
        idx        = (ptr > 2'd2) ? 2'd0 : ptr;
        // NOTE: blocking assignments here because idx/count are scan variables updated within one evaluation.
        for (int k = 0; k < 3; k++) begin
            if (req[idx] && (count < MAX_PKTS)) begin
                if (count == 2'd0) begin
                    first_idx = idx;
                end else begin
                    second_idx = idx;
                end
                count    = count + 2'd1;
                next_ptr = rr_inc(idx);
            end
            idx = rr_inc(idx);
        end
    end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-line HDMI period scheduler: data island with up to two packets, then video.
module hdmi_period_scheduler
    import hdmi_pkg::*;
(
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] hpos,
    input  logic       vactive,
    input  logic       island_en,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [4:0] pkt_word,
    output logic [2:0] mode,
    output logic [3:0] ctl
);

    state_t     state, next_state;
    logic [1:0] ptr;
    logic [1:0] n_q, sel0_q, sel1_q;
    logic [1:0] pick_count, pick_first, pick_second, pick_next_ptr;
    logic [2:0] masked_req;
    logic [9:0] data_end;
    logic [5:0] pkt_offset;
    logic [2:0] grant_d;
    logic [4:0] word_d;
    mode_t      mode_d;
    logic [3:0] ctl_d;

    assign masked_req = island_en ? req : 3'b000;

    hdmi_rr_pick2 u_pick (
        .req        (masked_req),
        .ptr        (ptr),
        .count      (pick_count),
        .first_idx  (pick_first),
        .second_idx (pick_second),
        .next_ptr   (pick_next_ptr)
    );

    // Latch the island decision once per line at the decision position.
    always_ff @(posedge pixel_clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset clears the abort-sensitive decision too.
        if (rst) begin
            ptr    <= 2'd0;
            n_q    <= 2'd0;
            sel0_q <= 2'd0;
            sel1_q <= 2'd0;
        end else if (hpos == DI_DECIDE) begin
            ptr    <= pick_next_ptr;
            n_q    <= pick_count;
            sel0_q <= pick_first;
            sel1_q <= pick_second;
        end
    end

    // Position just past the last data word of the island.
    always_comb begin
        data_end = (n_q == MAX_PKTS) ? DI_DATA_START + PKT_LEN + PKT_LEN
                                     : DI_DATA_START + PKT_LEN;
    end

    // State register.
    always_ff @(posedge pixel_clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next state keyed on hpos; any position outside a state's window falls back to idle.
    always_comb begin
        next_state = ST_IDLE;
        if (hpos == DI_START && n_q != 2'd0) next_state = ST_DI_PRE;
        else if (hpos == VID_PRE_START && vactive) next_state = ST_VID_PRE;

        case (state)
            ST_DI_PRE: begin
                if (hpos > DI_START && hpos < DI_GB_START) next_state = ST_DI_PRE;
                else if (hpos == DI_GB_START)              next_state = ST_DI_LGB;
            end
            ST_DI_LGB: begin
                if (hpos == DI_GB_START + 10'd1)     next_state = ST_DI_LGB;
                else if (hpos == DI_DATA_START)      next_state = ST_DI_DATA;
            end
            ST_DI_DATA: begin
                if (hpos > DI_DATA_START && hpos < data_end) next_state = ST_DI_DATA;
                else if (hpos == data_end)                   next_state = ST_DI_TGB;
            end
            ST_DI_TGB: begin
                if (hpos == data_end + 10'd1) next_state = ST_DI_TGB;
            end
            ST_VID_PRE: begin
                if (hpos > VID_PRE_START && hpos < VID_GB_START) next_state = ST_VID_PRE;
                else if (hpos == VID_GB_START)                   next_state = ST_VID_GB;
            end
            ST_VID_GB: begin
                if (hpos == VID_GB_START + 10'd1) next_state = ST_VID_GB;
                else if (hpos == VID_START)       next_state = ST_VIDEO;
            end
            ST_VIDEO: begin
                if (hpos > VID_START && hpos < VID_END) next_state = ST_VIDEO;
            end
            default: ;
        endcase
    end

    // Output decode for the position being entered.
    always_comb begin
        mode_d     = MODE_CONTROL;
        ctl_d      = 4'b0000;
        grant_d    = 3'b000;
        word_d     = 5'd0;
        pkt_offset = 6'(hpos - DI_DATA_START);
        case (next_state)
            ST_DI_PRE: begin
                mode_d = MODE_DI_PRE;
                ctl_d  = CTL_DI_PRE;
            end
            ST_DI_LGB, ST_DI_TGB: mode_d = MODE_DI_GB;
            ST_DI_DATA: begin
                mode_d  = MODE_DI_DATA;
                word_d  = pkt_offset[4:0];
                grant_d = onehot3(pkt_offset[5] ? sel1_q : sel0_q);
            end
            ST_VID_PRE: begin
                mode_d = MODE_VID_PRE;
                ctl_d  = CTL_VID_PRE;
            end
            ST_VID_GB: mode_d = MODE_VID_GB;
            ST_VIDEO:  mode_d = MODE_VIDEO;
            default: ;
        endcase
    end

    // Registered outputs, one cycle after the position is sampled.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            grant    <= 3'b000;
            pkt_word <= 5'd0;
            mode     <= MODE_CONTROL;
            ctl      <= 4'b0000;
        end else begin
            grant    <= grant_d;
            pkt_word <= word_d;
            mode     <= mode_d;
            ctl      <= ctl_d;
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Self-checking bench for hdmi_period_scheduler against a position-keyed line model.
module tb_hdmi_period_scheduler;
    import hdmi_pkg::*;

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hpos = 10'd0;
    logic       vactive = 1'b0;
    logic       island_en = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] grant;
    logic [4:0] pkt_word;
    logic [2:0] mode;
    logic [3:0] ctl;

    int total = 0;
    int bad = 0;

    // Reference model state: rotation pointer and this line's packet list.
    int m_ptr = 0;
    int m_n = 0;
    int m_sel[2] = '{0, 0};

    hdmi_period_scheduler dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .hpos      (hpos),
        .vactive   (vactive),
        .island_en (island_en),
        .req       (req),
        .grant     (grant),
        .pkt_word  (pkt_word),
        .mode      (mode),
        .ctl       (ctl)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Pick up to two requesters, walking the rotation from the model pointer.
    task automatic decide(input logic [2:0] r, input logic ie);
        int cnt = 0;
        int last = 0;
        if (ie) begin
            for (int k = 0; k < 3; k++) begin
                int idx = (m_ptr + k) % 3;
                if (r[idx] && cnt < 2) begin
                    m_sel[cnt] = idx;
                    cnt++;
                    last = idx;
                end
            end
        end
        if (cnt > 0) m_ptr = (last + 1) % 3;
        m_n = cnt;
    endtask

    // Expected {grant, pkt_word, mode, ctl} at line position p.
    function automatic logic [14:0] expect_at(input int p, input logic va);
        logic [2:0] g = 3'b000;
        logic [4:0] w = 5'd0;
        logic [2:0] m = MODE_CONTROL;
        logic [3:0] c = 4'b0000;
        int data_end = 14 + 32 * m_n;
        if (m_n > 0 && p >= 4 && p <= 11) begin
            m = MODE_DI_PRE;
            c = 4'b0101;
        end else if (m_n > 0 && p >= 12 && p <= 13) begin
            m = MODE_DI_GB;
        end else if (m_n > 0 && p >= 14 && p < data_end) begin
            m = MODE_DI_DATA;
            w = 5'((p - 14) % 32);
            g = 3'(1 << m_sel[(p - 14) / 32]);
        end else if (m_n > 0 && p >= data_end && p <= data_end + 1) begin
            m = MODE_DI_GB;
        end else if (va && p >= 134 && p <= 141) begin
            m = MODE_VID_PRE;
            c = 4'b0001;
        end else if (va && p >= 142 && p <= 143) begin
            m = MODE_VID_GB;
        end else if (va && p >= 144 && p <= 783) begin
            m = MODE_VIDEO;
        end
        return {g, w, m, c};
    endfunction

    // Drive one position, sample the registered result, and produce the model's expectation.
    task automatic step(input int p, input logic [2:0] r, input logic ie, input logic va,
                        input logic rs, output logic [14:0] obs, output logic [14:0] exp);
        @(negedge pixel_clk);
        hpos = 10'(p);
        req = r;
        island_en = ie;
        vactive = va;
        rst = rs;
        @(posedge pixel_clk);
        #1;
        obs = {grant, pkt_word, mode, ctl};
        if (rs) begin
            m_ptr = 0;
            m_n = 0;
            exp = {3'b000, 5'd0, MODE_CONTROL, 4'b0000};
        end else begin
            if (p == 2) decide(r, ie);
            exp = expect_at(p, va);
        end
    endtask

    task automatic test_reset();
        logic [14:0] obs, exp;
        for (int i = 0; i < 6; i++) begin
            step(int'($urandom_range(0, 799)), 3'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b1, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset cyc=%0d actual=%h required=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_two_packets();
        logic [14:0] obs, exp;
        for (int p = 0; p < 800; p++) begin
            step(p, 3'b111, 1'b1, 1'b0, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL two_pkt_111 pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
        for (int p = 0; p < 800; p++) begin
            step(p, 3'b101, 1'b1, 1'b0, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL two_pkt_101 pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
    endtask

    task automatic test_single_packet();
        logic [14:0] obs, exp;
        for (int p = 0; p < 800; p++) begin
            step(p, 3'b010, 1'b1, 1'b0, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL single_pkt pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
    endtask

    task automatic test_late_request();
        logic [14:0] obs, exp;
        for (int p = 0; p < 800; p++) begin
            step(p, (p >= 3) ? 3'b111 : 3'b000, 1'b1, 1'b0, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL late_req pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
        for (int p = 0; p < 800; p++) begin
            step(p, 3'b111, 1'b1, 1'b0, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL late_req_next pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
    endtask

    task automatic test_video();
        logic [14:0] obs, exp;
        for (int p = 0; p < 800; p++) begin
            step(p, 3'b000, 1'b1, 1'b1, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL video_on pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
        for (int p = 0; p < 800; p++) begin
            step(p, 3'b000, 1'b1, 1'b0, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL video_off pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_island();
        logic [14:0] obs, exp;
        for (int p = 0; p < 800; p++) begin
            step(p, 3'b111, 1'b1, 1'b0, (p >= 30 && p <= 32), obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rst_mid pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
        for (int p = 0; p < 800; p++) begin
            step(p, 3'b111, 1'b1, 1'b0, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL rst_mid_next pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
    endtask

    task automatic test_island_disabled();
        logic [14:0] obs, exp;
        for (int p = 0; p < 800; p++) begin
            step(p, 3'b111, 1'b0, 1'b0, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL island_off pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
        for (int p = 0; p < 800; p++) begin
            step(p, 3'b111, 1'b1, 1'b0, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL island_off_next pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
    endtask

    task automatic test_hpos_jump();
        logic [14:0] obs, exp;
        for (int p = 0; p < 800; p++) begin
            if (p > 20 && p < 600) continue;
            step(p, 3'b111, 1'b1, 1'b0, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL hpos_jump pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
        for (int p = 0; p < 800; p++) begin
            step(p, 3'b011, 1'b1, 1'b1, 1'b0, obs, exp);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL hpos_jump_next pos=%0d actual=%h required=%h", p, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [14:0] obs, exp;
        for (int line = 0; line < 6; line++) begin
            logic [2:0] r = 3'($urandom_range(0, 7));
            logic ie = 1'($urandom_range(0, 1));
            logic va = 1'($urandom_range(0, 1));
            for (int p = 0; p < 800; p++) begin
                step(p, r, ie, va, 1'b0, obs, exp);
                total++;
                if (obs !== exp) begin
                    bad++;
                    $display("FAIL random line=%0d pos=%0d actual=%h required=%h", line, p, obs, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_packets();
        test_single_packet();
        test_reset_mid_island();
        test_late_request();
        test_video();
        test_island_disabled();
        test_hpos_jump();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
